// File: rtl/histogram_align_accumulator_if.sv
// Beat-in / group-result-out bundle for histogram_align_accumulator.
// master = producer/consumer side, slave = the accumulator itself.
interface histogram_align_accumulator_if #(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0][5:0]     in_counts;
  logic [SHIFT_W-1:0]   in_shift;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic [7:0]           out_beats;
  logic                 out_overflow;

  modport master (
    output in_valid, in_counts, in_shift, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_overflow
  );

  modport slave (
    input  in_valid, in_counts, in_shift, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_overflow
  );
endinterface

// File: rtl/histogram_align_accumulator.sv
// Aligns 16 signed bin counts (bin k weighted 2^k, plus a per-beat shift) and
// accumulates beats into one signed, overflow-flagged sum per group.
module histogram_align_accumulator #(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  histogram_align_accumulator_if.slave  bus
);

  logic [ACC_W-1:0]   align;
  logic [ACC_W-1:0]   ext;
  logic [SHIFT_W-1:0] shamt;

  logic               s1_valid;
  logic               s1_last;
  logic [ACC_W-1:0]   s1_sum;

  logic [ACC_W-1:0]   acc;
  logic [7:0]         beats;
  logic               ovf;

  logic               stall;
  logic               accept;
  logic               advance;
  logic [ACC_W-1:0]   sum;
  logic               ovf_now;
  logic [7:0]         beats_inc;

  assign shamt = bus.in_shift;

  always_comb begin
    align = '0;
    ext   = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      ext   = {{(ACC_W-6){bus.in_counts[k][5]}}, bus.in_counts[k]};
      align = align + (ext << k);
    end
    align = align << shamt;
  end

  // A held result only blocks stage 2; stage 1 may still fill once behind it.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~s1_valid | ~stall;
  assign accept       = bus.in_valid & bus.in_ready;
  assign advance      = s1_valid & ~stall;

  assign sum       = acc + s1_sum;
  assign ovf_now   = (acc[ACC_W-1] == s1_sum[ACC_W-1]) & (sum[ACC_W-1] != acc[ACC_W-1]);
  assign beats_inc = (&beats) ? beats : beats + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= bus.in_last;
      s1_sum   <= align;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc              <= '0;
      beats            <= '0;
      ovf              <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_beats    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      // A last beat loading on the retire edge overrides the clear above.
      if (advance) begin
        if (s1_last) begin
          bus.out_valid    <= 1'b1;
          bus.out_data     <= sum;
          bus.out_beats    <= beats_inc;
          bus.out_overflow <= ovf | ovf_now;
          acc              <= '0;
          beats            <= '0;
          ovf              <= 1'b0;
        end else begin
          acc   <= sum;
          beats <= beats_inc;
          ovf   <= ovf | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_histogram_align_accumulator.sv
// Randomised and directed bench for histogram_align_accumulator against an
// arithmetic group-sum reference model.
module tb_histogram_align_accumulator;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 3;
  localparam longint LIM = longint'(1) << 31;
  localparam longint BIG = 134215680;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  histogram_align_accumulator_if #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) bus();
  histogram_align_accumulator #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    longint data;
    int     beats;
    bit     ovf;
  } res_t;

  res_t   exp_q[$];
  longint m_acc = 0;
  int     m_n = 0;
  bit     m_ovf = 0;
  int     tests = 0;
  int     failed = 0;
  int     retired = 0;
  longint last_data = 0;
  int     last_beats = 0;
  bit     last_ovf = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint beat_val(input logic [15:0][5:0] c, input int sh);
    longint v = 0;
    for (int k = 0; k < 16; k++)
      v += longint'($signed(c[k])) * (longint'(1) << k);
    return v * (longint'(1) << sh);
  endfunction

  task automatic model_beat(input logic [15:0][5:0] c, input int sh, input bit last);
    longint exact;
    exact = m_acc + beat_val(c, sh);
    if (exact >= LIM || exact < -LIM) m_ovf = 1'b1;
    m_acc = longint'(int'(exact));
    m_n   = (m_n < 255) ? m_n + 1 : 255;
    if (last) begin
      exp_q.push_back('{m_acc, m_n, m_ovf});
      m_acc = 0;
      m_n   = 0;
      m_ovf = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_n   = 0;
      m_ovf = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          check("out_data", longint'($signed(bus.out_data)), exp_q[0].data);
          check("out_beats", longint'(bus.out_beats), longint'(exp_q[0].beats));
          check("out_overflow", longint'(bus.out_overflow), longint'(exp_q[0].ovf));
          if (bus.out_ready) begin
            last_data  = longint'($signed(bus.out_data));
            last_beats = int'(bus.out_beats);
            last_ovf   = bus.out_overflow;
            void'(exp_q.pop_front());
            retired++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_beat(bus.in_counts, int'(bus.in_shift), bus.in_last);
    end
  end

  function automatic logic [15:0][5:0] rand_counts();
    logic [15:0][5:0] c;
    for (int k = 0; k < 16; k++)
      c[k] = 6'(int'($urandom_range(32)) - 16);
    return c;
  endfunction

  task automatic send(input logic [15:0][5:0] c, input int sh, input bit last);
    int n = 0;
    bus.in_counts = c;
    bus.in_shift  = SHIFT_W'(sh);
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_retire(input int target);
    int n = 0;
    while (retired < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (retired < target) check("retire_timeout", longint'(retired), longint'(target));
    #1;
  endtask

  logic [15:0][5:0] c;
  int base;
  int acc_cnt;
  int n;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_counts = '0;
    bus.in_shift  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_beats", longint'(bus.out_beats), 0);
    check("rst_out_overflow", longint'(bus.out_overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // Single beat with latency check.
    c = '0; c[0] = 6'd3; c[4] = 6'h3E;
    bus.in_counts = c; bus.in_shift = '0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1_valid", longint'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_edge2_valid", longint'(bus.out_valid), 1);
    wait_retire(1);
    check("single_data", last_data, -29);
    check("single_beats", longint'(last_beats), 1);
    check("single_ovf", longint'(last_ovf), 0);

    // Two-beat group.
    base = retired;
    send(c, 0, 1'b0);
    c = '0; c[15] = 6'd16;
    send(c, 7, 1'b1);
    wait_retire(base + 1);
    check("two_data", last_data, 67108835);
    check("two_beats", longint'(last_beats), 2);

    // 16 and 17 full-scale beats around the signed overflow boundary.
    c = {16{6'd16}};
    base = retired;
    for (int i = 0; i < 16; i++) send(c, 7, i == 15);
    wait_retire(base + 1);
    check("ovf16_data", last_data, 16 * BIG);
    check("ovf16_flag", longint'(last_ovf), 0);
    base = retired;
    for (int i = 0; i < 17; i++) send(c, 7, i == 16);
    wait_retire(base + 1);
    check("ovf17_data", last_data, 17 * BIG - (longint'(1) << 32));
    check("ovf17_beats", longint'(last_beats), 17);
    check("ovf17_flag", longint'(last_ovf), 1);

    // Backpressure: one result held, only one more beat fits.
    bus.out_ready = 1'b0;
    base = retired;
    c = '0; c[1] = 6'h39;
    send(c, 2, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("bp_held_valid", longint'(bus.out_valid), 1);
    c = '0; c[3] = 6'd9;
    bus.in_counts = c; bus.in_shift = '0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", longint'(acc_cnt), 1);
    check("bp_in_ready", longint'(bus.in_ready), 0);
    check("bp_stable_data", longint'($signed(bus.out_data)), -56);
    bus.out_ready = 1'b1;
    wait_retire(base + 2);
    check("bp_second_data", last_data, 72);

    // Back-to-back single-beat groups: out_valid stays high.
    base = retired;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        bus.in_counts = rand_counts();
        bus.in_shift  = SHIFT_W'($urandom_range(7));
        bus.in_last   = 1'b1;
        bus.in_valid  = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) check("b2b_out_valid", longint'(bus.out_valid), 1);
      if (i < 6) check("b2b_in_ready", longint'(bus.in_ready), 1);
      @(posedge clk); #1;
    end
    wait_retire(base + 6);

    // Beat counter saturation with all-zero beats.
    base = retired;
    for (int i = 0; i < 260; i++) send('0, 0, i == 259);
    wait_retire(base + 1);
    check("sat_beats", longint'(last_beats), 255);
    check("sat_data", last_data, 0);

    // Reset mid-group.
    c = '0; c[7] = 6'd11;
    send(c, 3, 1'b0);
    send(c, 3, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(bus.out_valid), 0);
    check("mid_rst_data", longint'(bus.out_data), 0);
    check("mid_rst_beats", longint'(bus.out_beats), 0);
    check("mid_rst_ovf", longint'(bus.out_overflow), 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", longint'(bus.in_ready), 1);
    base = retired;
    c = '0; c[2] = 6'd5;
    send(c, 1, 1'b1);
    wait_retire(base + 1);
    check("post_rst_data", last_data, 40);
    check("post_rst_beats", longint'(last_beats), 1);

    // Random groups with random consumer backpressure.
    begin
      int  left = 300;
      int  grp = 0;
      bit  have = 0;
      bit  took;
      int  cyc = 0;
      while ((left > 0 || have) && cyc < 5000) begin
        @(negedge clk);
        took = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        cyc++;
        if (took) have = 0;
        if (!have && left > 0) begin
          if (grp == 0) grp = int'($urandom_range(5)) + 1;
          grp--;
          bus.in_counts = rand_counts();
          bus.in_shift  = SHIFT_W'($urandom_range(7));
          bus.in_last   = (grp == 0);
          have = 1;
          left--;
        end
        bus.in_valid  = have;
        bus.out_ready = ($urandom_range(3) != 0);
      end
      if (cyc >= 5000) check("rand_timeout", 0, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
        @(posedge clk); #1; n++;
      end
      check("rand_drain", longint'(exp_q.size()), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
